// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter; tick_c pulses for one cycle at count DIV-1.
module uart_baud_tick #(
  parameter int unsigned DIV = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_c = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || tick_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first by default; define UART_TX_PARITY_EN
// to append an even parity bit between the data bits and the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx: bit period DIV must be at least 2 clock cycles");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bits_check
    $error("uart_tx: DATA_BITS must be in 5..9");
  end

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 busy_q, busy_d;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Counter is held at zero while idle so each frame starts on a fresh bit period.
  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear_i(state_q == IDLE),
    .tick_c (tick)
  );

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d = START;
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so it changes with the state.
    tx_d = STOP_BIT;
    case (state_d)
      START: tx_d = START_BIT;
      DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      default: tx_d = STOP_BIT;
    endcase

    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      tx_q       <= STOP_BIT;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at DIV=10 (1 MHz clock, 100 kbaud).
module tb_uart_tx;

  localparam int DIV = 10;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = (DB + 3) * DIV;
`else
  localparam int FRAME = (DB + 2) * DIV;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int total = 0;
  int bad   = 0;

  uart_tx #(
    .CLK_HZ   (1_000_000),
    .BAUD     (100_000),
    .DATA_BITS(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Expected line level k cycles after the accept cycle (k = 1..FRAME).
  function automatic logic exp_line(input logic [7:0] d, input int k);
    int b;
    if (k <= DIV) return 1'b0;
    b = (k - DIV - 1) / DIV;
    if (b < DB) return d[b];
`ifdef UART_TX_PARITY_EN
    if (b == DB) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_values tx=%b rdy=%b busy=%b want 1 1 0", tx, tx_ready, busy);
    end
    tx_valid = 1'b1; tx_data = 8'h55;
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_priority tx=%b rdy=%b busy=%b want 1 1 0", tx, tx_ready, busy);
    end
    tx_valid = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset tx=%b rdy=%b busy=%b want 1 1 0", tx, tx_ready, busy);
    end
  endtask

  task automatic test_single(input logic [7:0] d);
    @(negedge clk);
    tx_data = d; tx_valid = 1'b1;
    total++;
    if (tx_ready !== 1'b1) begin
      bad++; $display("FAIL single_ready_pre d=%h rdy=%b want 1", d, tx_ready);
    end
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      total++;
      if (tx !== exp_line(d, k) || busy !== 1'b1 || tx_ready !== 1'b0) begin
        bad++;
        $display("FAIL single_frame d=%h k=%0d tx=%b busy=%b rdy=%b want tx=%b busy=1 rdy=0",
                 d, k, tx, busy, tx_ready, exp_line(d, k));
      end
    end
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_end d=%h tx=%b rdy=%b busy=%b want 1 1 0", d, tx, tx_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    tx_data = 8'h00; tx_valid = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 1) tx_data = 8'hFF;
      total++;
      if (tx !== exp_line(8'h00, k) || busy !== 1'b1 || tx_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_first k=%0d tx=%b busy=%b rdy=%b want tx=%b busy=1 rdy=0",
                 k, tx, busy, tx_ready, exp_line(8'h00, k));
      end
    end
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_gap tx=%b rdy=%b busy=%b want 1 1 0", tx, tx_ready, busy);
    end
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      total++;
      if (tx !== exp_line(8'hFF, k) || busy !== 1'b1 || tx_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_second k=%0d tx=%b busy=%b rdy=%b want tx=%b busy=1 rdy=0",
                 k, tx, busy, tx_ready, exp_line(8'hFF, k));
      end
    end
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_end rdy=%b busy=%b want 1 0", tx_ready, busy);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    tx_data = 8'h5A; tx_valid = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 1)  tx_valid = 1'b0;
      if (k == 30) begin tx_valid = 1'b1; tx_data = 8'hFF; end
      if (k == 31) tx_valid = 1'b0;
      total++;
      if (tx !== exp_line(8'h5A, k) || busy !== 1'b1 || tx_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_frame k=%0d tx=%b busy=%b rdy=%b want tx=%b busy=1 rdy=0",
                 k, tx, busy, tx_ready, exp_line(8'h5A, k));
      end
    end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
        bad++; $display("FAIL stall_no_queue k=%0d tx=%b busy=%b rdy=%b want 1 0 1", k, tx, busy, tx_ready);
      end
    end
  endtask

  task automatic test_data_stability();
    @(negedge clk);
    tx_data = 8'h3C; tx_valid = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 1) begin tx_valid = 1'b0; tx_data = 8'hC3; end
      total++;
      if (tx !== exp_line(8'h3C, k)) begin
        bad++; $display("FAIL stability k=%0d tx=%b want %b", k, tx, exp_line(8'h3C, k));
      end
    end
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1) begin
      bad++; $display("FAIL stability_end rdy=%b want 1", tx_ready);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    tx_data = 8'hF0; tx_valid = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      total++;
      if (tx !== exp_line(8'hF0, k) || busy !== 1'b1) begin
        bad++; $display("FAIL rstmid_pre k=%0d tx=%b busy=%b want tx=%b busy=1", k, tx, busy, exp_line(8'hF0, k));
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_abort tx=%b rdy=%b busy=%b want 1 1 0", tx, tx_ready, busy);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        bad++; $display("FAIL rstmid_no_resume k=%0d tx=%b busy=%b want 1 0", k, tx, busy);
      end
    end
    test_single(8'h81);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] d, input logic par);
    test_single(d);
    @(negedge clk);
    tx_data = d; tx_valid = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      if (k == (DB + 1) * DIV + 5) begin
        total++;
        if (tx !== par) begin
          bad++; $display("FAIL parity_bit d=%h tx=%b want %b", d, tx, par);
        end
      end
    end
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1) begin
      bad++; $display("FAIL parity_len d=%h rdy=%b want 1", d, tx_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single(8'hA5);
    test_back_to_back();
    test_stall();
    test_data_stability();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: accepts a parallel byte over a valid/ready handshake and shifts it out on a single line.
- Frame format is 8N1 by default, sent LSB first.
- Partner to the board's UART receive path; carries score and game-state telemetry from the game core to the host PC over the USB-UART bridge.
- All outputs are registered; reset is synchronous.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- BAUD, 115_200: line bit rate.
- DATA_BITS, 8: payload bits per frame, legal range 5..9.

Ports:
- clk  input  1  posedge active clock.
- rst  input  1  reset rst, synchronous, active-high; clock clk.
- tx_data  input  DATA_BITS  payload; sampled only at the cycle of acceptance.
- tx_valid  input  1  producer has data.
- tx_ready  output  1  transmitter can accept; high only in IDLE.
- tx  output  1  serial line; idles high.
- busy  output  1  high from the cycle after acceptance to the end of the stop bit.

Behaviour:
- Bit period: DIV = (CLK_HZ + BAUD/2) / BAUD, computed as an integer at elaboration. Default DIV = 868.
  - Elaboration error if DIV < 2.
  - Baud counter width = $clog2(DIV).
- Reset values: tx=1, tx_ready=1, busy=0; FSM in IDLE; counters cleared.
- Accept rule: data is taken in cycle N when tx_valid && tx_ready.
  - tx_data is latched into the shift register in cycle N.
  - Later changes to tx_data have no effect on the frame in flight.
- tx_valid while tx_ready=0 is ignored, not queued; the producer must hold it.
- FSM states: IDLE, START, DATA, PARITY (present only with the feature enabled), STOP.
  - IDLE -> START on accept. tx=0, tx_ready=0, busy=1, all from cycle N+1.
  - START holds DIV cycles, then -> DATA with bit index 0.
  - DATA: tx = shift_reg[0] for DIV cycles, then shift right and increment the index. After DATA_BITS bits -> PARITY or STOP.
  - STOP: tx=1 for DIV cycles, then -> IDLE. tx_ready=1 and busy=0 in the first IDLE cycle.
- The baud counter restarts at 0 on every state or bit change, so there is no drift across a frame.
- Timing:
  - First start-bit cycle is N+1.
  - Frame length = (1 + DATA_BITS + 1) * DIV cycles.
  - Earliest next accept is the first IDLE cycle, so back-to-back frames have no extra idle bit-time.
- If tx_valid stays high continuously, the next frame is accepted in the first IDLE cycle; its start bit follows one cycle later.
- Reset mid-frame: frame aborted. tx=1, tx_ready=1, busy=0 in the cycle after rst is sampled high. No resume.
- rst has priority over accept in the same cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx = even parity (XOR of all latched data bits) for DIV cycles.
  - Frame length = (DATA_BITS + 3) * DIV.
- Undefined:
  - No PARITY state and no parity logic; DATA goes directly to STOP.
  - Frame length = (DATA_BITS + 2) * DIV.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - the function baud_div(clk_hz, baud), returning the rounded DIV;
  - shared frame constants START_BIT=0 and STOP_BIT=1.
- The package is also used by the receiver.
- One natural sub-module: uart_baud_tick.
  - Parameterised by DIV, with a clear input (restart) and a 1-cycle tick output at count DIV-1.
  - Reusable by the receiver at 16x oversampling.

Test Plan:
- Single byte: CLK_HZ=1_000_000, BAUD=100_000 (DIV=10). Send 0xA5, accept at cycle N.
  - tx=0 during N+1..N+10.
  - Data bits 1,0,1,0,0,1,0,1 for 10 cycles each.
  - Stop=1 during N+91..N+100.
  - tx_ready=1 at N+101.
- Back-to-back: tx_valid held high with 0x00 then 0xFF.
  - Second accept exactly 101 cycles after the first.
  - No idle gap beyond 1 cycle.
  - Line shows 8 lows, then stop, then start, then 8 highs.
- Stalled producer: pulse tx_valid while busy.
  - Ignored; tx_ready stays 0.
  - Only the first frame appears on tx.
- Data stability: change tx_data from 0x3C to 0xC3 one cycle after accept.
  - Serial output is still 0x3C.
- Reset mid-frame: assert rst during data bit 3.
  - Next cycle: tx=1, tx_ready=1, busy=0.
  - A new 0x81 frame then transmits correctly.
- Parity (UART_TX_PARITY_EN defined): send 0x07, then 0x03.
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - Frame length 110 cycles with DIV=10.
